// File: rtl/soc_system_switch_debounce.sv
// Switch input conditioner: per-bit synchroniser followed by a consecutive-mismatch debouncer.
// sw_clean only changes after a level has been held for DEBOUNCE_CYCLES synchronised cycles.
module soc_system_switch_debounce #(
    parameter int unsigned    WIDTH           = 9,
    parameter int unsigned    SYNC_STAGES     = 2,
    parameter int unsigned    DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned    CNT_W           = 20,
    parameter logic [WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_changed,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] cnt_nz;
    logic             busy_q;

    // Synchroniser chain; the last stage is the only view of the pins the debouncer sees
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= INIT_VALUE;
            end
        end else begin
            sync_q[0] <= sw_raw;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             clean_q, clean_d;
        logic             changed_q, changed_d;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                clean_q   <= INIT_VALUE[g];
                changed_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                clean_q   <= clean_d;
                changed_q <= changed_d;
            end
        end

        // Any matching cycle drops back to IDLE, so only an unbroken mismatch run is accepted
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            clean_d   = clean_q;
            changed_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync[g] != clean_q) begin
                        if (DEBOUNCE_CYCLES == 32'd1) begin
                            clean_d   = sync[g];
                            changed_d = 1'b1;
                        end else begin
                            state_d = COUNT;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                COUNT: begin
                    if (sync[g] == clean_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        clean_d   = sync[g];
                        changed_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign sw_clean[g]   = clean_q;
        assign sw_changed[g] = changed_q;
        assign cnt_nz[g]     = (cnt_q != '0);
    end

    // busy trails the counters by one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |cnt_nz;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_soc_system_switch_debounce.sv
// Directed bench for soc_system_switch_debounce with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Expected outputs are queued when stimulus is applied and checked at the following negedge.
module tb_soc_system_switch_debounce;

    localparam int unsigned W = 9;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_clean;
    logic [W-1:0] sw_changed;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] clean;
        logic [W-1:0] chg;
        logic         busy;
    } exp_t;

    exp_t sb[$];

    soc_system_switch_debounce #(
        .WIDTH          (9),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .INIT_VALUE     (9'h000)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sw_raw    (sw_raw),
        .sw_clean  (sw_clean),
        .sw_changed(sw_changed),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic compare_pop();
        exp_t e;
        e = sb.pop_front();
        vectors++;
        assert (sw_clean === e.clean) else begin
            miscompares++;
            $error("FAIL %s sw_clean observed=%h expected=%h", e.tag, sw_clean, e.clean);
        end
        vectors++;
        assert (sw_changed === e.chg) else begin
            miscompares++;
            $error("FAIL %s sw_changed observed=%h expected=%h", e.tag, sw_changed, e.chg);
        end
        vectors++;
        assert (busy === e.busy) else begin
            miscompares++;
            $error("FAIL %s busy observed=%b expected=%b", e.tag, busy, e.busy);
        end
    endtask

    task automatic check_now(input string tag, input logic [W-1:0] c,
                             input logic [W-1:0] ch, input logic b);
        sb.push_back('{tag, c, ch, b});
        #1;
        compare_pop();
    endtask

    task automatic tick(input string tag, input logic [W-1:0] c,
                        input logic [W-1:0] ch, input logic b);
        sb.push_back('{tag, c, ch, b});
        @(posedge clk);
        @(negedge clk);
        compare_pop();
    endtask

    // Held step: clean flips on edge 6, pulse on edge 6 only, busy on edges 4..6
    task automatic run_step(input string tag, input logic [W-1:0] pre,
                            input logic [W-1:0] post, input logic [W-1:0] chg, input int n);
        for (int k = 1; k <= n; k++) begin
            tick(tag, (k >= 6) ? post : pre, (k == 6) ? chg : 9'h000,
                 (k >= 4) && (k <= 6) && (chg != 9'h000));
        end
    endtask

    initial begin
        logic [15:0] raw_seq;
        logic [15:0] busy_seq;
        raw_seq  = 16'hFF33;
        busy_seq = 16'h3998;

        reset_n = 1'b0;
        sw_raw  = 9'h1FF;
        @(negedge clk);
        check_now("rst_async", 9'h000, 9'h000, 1'b0);
        tick("rst_hold", 9'h000, 9'h000, 1'b0);
        tick("rst_hold", 9'h000, 9'h000, 1'b0);

        reset_n = 1'b1;
        run_step("rst_release", 9'h000, 9'h1FF, 9'h1FF, 8);

        sw_raw = 9'h000;
        run_step("all_off", 9'h1FF, 9'h000, 9'h1FF, 8);

        sw_raw = 9'h008;
        run_step("clean_step", 9'h000, 9'h008, 9'h008, 8);

        // bit0 bounces 1,1,0,0,1,1,0,0 then holds 1
        for (int k = 1; k <= 16; k++) begin
            sw_raw = 9'h008 | 9'(raw_seq[k-1]);
            tick("bounce", (k >= 14) ? 9'h009 : 9'h008, (k == 14) ? 9'h001 : 9'h000,
                 busy_seq[k-1]);
        end

        // bit5 high for only three cycles: one short of acceptance
        for (int k = 1; k <= 9; k++) begin
            sw_raw = (k <= 3) ? 9'h029 : 9'h009;
            tick("glitch", 9'h009, 9'h000, (k >= 4) && (k <= 6));
        end

        sw_raw = 9'h000;
        run_step("clear", 9'h009, 9'h000, 9'h009, 8);

        sw_raw = 9'h101;
        run_step("simul", 9'h000, 9'h101, 9'h101, 8);

        sw_raw = 9'h111;
        for (int k = 1; k <= 4; k++) begin
            tick("mid_count", 9'h101, 9'h000, k == 4);
        end
        reset_n = 1'b0;
        check_now("mid_rst", 9'h000, 9'h000, 1'b0);
        tick("mid_rst_hold", 9'h000, 9'h000, 1'b0);
        tick("mid_rst_hold", 9'h000, 9'h000, 1'b0);
        reset_n = 1'b1;
        run_step("rst_restart", 9'h000, 9'h111, 9'h111, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
